// File: rtl/la_rrarb3_pkg.sv
// ---------------------------------------------------------------------------
// la_rrarb3_pkg
// Shared types and helpers for the three-requester round-robin arbiter.
//   NREQ        : number of requesters
//   idx_t       : requester index / owner code (3 = idle)
//   hold_width  : width of the ownership hold counter for a given MAXHOLD
// ---------------------------------------------------------------------------
package la_rrarb3_pkg;

    localparam int NREQ = 3;

    typedef logic [1:0] idx_t;

    // clog2(maxhold+1), but never narrower than one bit so that a
    // disabled preemption (maxhold == 0) still yields a legal vector.
    function automatic int hold_width(input int maxhold);
        int w;
        w = $clog2(maxhold + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/la_rrpick3.sv
// ---------------------------------------------------------------------------
// la_rrpick3
// Combinational round-robin picker for three requesters.  The search starts
// at (last+1) mod 3 and wraps, so the requester that owned last is
// considered last.
//   req   : request vector (already masked by the caller if needed)
//   last  : index of the most recent owner
//   pick  : one-hot winner (zero when no request)
//   idx   : index of the winner (0 when no request)
//   valid : a winner exists
// ---------------------------------------------------------------------------
module la_rrpick3
    import la_rrarb3_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            last,
    output logic [NREQ-1:0] pick,
    output idx_t            idx,
    output logic            valid
);

    int   cand_i;
    idx_t cand;

    always_comb begin
        pick   = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_i = 0;
        cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_i = (int'(last) + i) % NREQ;
            cand   = idx_t'(cand_i);
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/la_rrarb3.sv
// ---------------------------------------------------------------------------
// la_rrarb3
// Three-requester round-robin arbiter with hold-time preemption.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants the resource; gnt[i] (registered) rises one edge later when it wins
// and stays high while req[i] stays high.  Dropping req[i] releases the
// resource at the next edge, where the next requester is granted directly.
// An owner that has held the resource for MAXHOLD cycles while someone else
// waits is rotated out; preempt pulses in the first cycle of the new grant.
//
// Parameters:
//   PROP      : implementation selector, carried for compatibility only
//   MAXHOLD   : max consecutive owned cycles before preemption (0 = never)
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   req[2:0]  : per-requester request level
//   gnt[2:0]  : registered one-hot-or-zero grant
//   owner     : current grantee index, 3 when idle
//   busy      : gnt is non-zero
//   preempt   : one-cycle pulse after a forced rotation
//   dbg_state : FSM state (0 = IDLE, 1 = OWN)
// ---------------------------------------------------------------------------
module la_rrarb3
    import la_rrarb3_pkg::*;
#(
    parameter string PROP    = "DEFAULT",
    parameter int    MAXHOLD = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output idx_t            owner,
    output logic            busy,
    output logic            preempt,
    output logic            dbg_state
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_OWN     = 1'b1;
    localparam idx_t OWNER_IDLE = 2'd3;
    localparam idx_t LAST_RESET = 2'd2;   // requester 0 wins first

    localparam int            HW         = hold_width(MAXHOLD);
    localparam logic [HW-1:0] HOLD_SAT   = HW'(MAXHOLD);
    localparam logic [HW-1:0] HOLD_LIM   = (MAXHOLD > 0) ? HW'(MAXHOLD - 1) : '0;
    localparam bit            PREEMPT_EN = (MAXHOLD > 0);

    logic            state_q,   state_n;
    logic [NREQ-1:0] gnt_q,     gnt_n;
    idx_t            owner_q,   owner_n;
    idx_t            last_q,    last_n;
    logic [HW-1:0]   hold_q,    hold_n;
    logic            preempt_q, preempt_n;

    // The current owner is masked out of the candidate set: on release its
    // request is already low, and on preemption it must not re-win.
    logic [NREQ-1:0] cand_req;
    logic [NREQ-1:0] pick;
    idx_t            pick_idx;
    logic            pick_valid;
    logic            owner_keep;

    assign cand_req   = req & ~gnt_q;
    assign owner_keep = |(req & gnt_q);

    la_rrpick3 u_pick (
        .req   (cand_req),
        .last  (last_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= OWNER_IDLE;
            last_q    <= LAST_RESET;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            owner_q   <= owner_n;
            last_q    <= last_n;
            hold_q    <= hold_n;
            preempt_q <= preempt_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        owner_n   = owner_q;
        last_n    = last_q;
        hold_n    = hold_q;
        preempt_n = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n = ST_OWN;
                    gnt_n   = pick;
                    owner_n = pick_idx;
                    last_n  = pick_idx;
                    hold_n  = '0;
                end
            end
            ST_OWN: begin
                if (!owner_keep) begin
                    // Release: hand over with no idle gap, or go idle.
                    if (pick_valid) begin
                        gnt_n   = pick;
                        owner_n = pick_idx;
                        last_n  = pick_idx;
                        hold_n  = '0;
                    end else begin
                        state_n = ST_IDLE;
                        gnt_n   = '0;
                        owner_n = OWNER_IDLE;
                        hold_n  = '0;
                    end
                end else if (PREEMPT_EN && (hold_q >= HOLD_LIM) && pick_valid) begin
                    // >= rather than == so a saturated owner is still
                    // rotated out when a competitor shows up late.
                    gnt_n     = pick;
                    owner_n   = pick_idx;
                    last_n    = pick_idx;
                    hold_n    = '0;
                    preempt_n = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_n = hold_q + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
                owner_n = OWNER_IDLE;
                hold_n  = '0;
            end
        endcase
    end

    // Outputs: all taken from registered state so they agree every cycle.
    always_comb begin
        gnt       = gnt_q;
        owner     = owner_q;
        busy      = |gnt_q;
        preempt   = preempt_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_la_rrarb3.sv
// ---------------------------------------------------------------------------
// tb_la_rrarb3
// Self-checking bench for la_rrarb3 (MAXHOLD = 15).  A behavioural model
// tracks the owner as an integer, the number of cycles it has owned, and
// the last winner; every edge is compared against it.
// ---------------------------------------------------------------------------
module tb_la_rrarb3;

    localparam int MH = 15;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;
    logic       dbg_state;

    int n_cmp;
    int n_bad;

    // Reference model state
    int m_owner;   // -1 when idle
    int m_last;
    int m_held;    // owned cycles including the current one
    bit m_pre;

    la_rrarb3 #(
        .PROP    ("DEFAULT"),
        .MAXHOLD (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .preempt   (preempt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_first(input logic [2:0] r, input int last);
        for (int i = 1; i <= 3; i++) begin
            if (r[(last + i) % 3]) return (last + i) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 2;
        m_held  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] r);
        logic [2:0] others;
        int w;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = rr_first(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 1;
            end
        end else if (!r[m_owner]) begin
            w = rr_first(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 1;
            end else begin
                m_owner = -1; m_held = 0;
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (MH > 0 && m_held >= MH && others != 3'b000) begin
                w = rr_first(others, m_last);
                m_owner = w; m_last = w; m_held = 1; m_pre = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [2:0] exp_gnt();
        logic [2:0] g;
        g = 3'b000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    // ---------------- driver tasks ----------------
    // Apply r for the coming edge (already at a negedge), then compare.
    task automatic eval(input logic [2:0] r);
        model_step(r);
        @(posedge clk);
        #1;
        check("gnt",     32'(gnt),       32'(exp_gnt()));
        check("owner",   32'(owner),     (m_owner < 0) ? 32'd3 : 32'(m_owner));
        check("busy",    32'(busy),      32'(m_owner >= 0));
        check("preempt", 32'(preempt),   32'(m_pre));
        check("state",   32'(dbg_state), 32'(m_owner >= 0));
        check("onehot",  32'($countones(gnt) <= 1), 32'd1);
        check("busy_eq", 32'(busy == (|gnt)), 32'd1);
        check("gnt_req", 32'(gnt & ~r), 32'd0);
    endtask

    task automatic step(input logic [2:0] r);
        @(negedge clk);
        req = r;
        eval(r);
    endtask

    task automatic do_reset(input logic [2:0] r);
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b000;
        #1;
        check("rst_gnt",     32'(gnt),     32'd0);
        check("rst_owner",   32'(owner),   32'd3);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_preempt", 32'(preempt), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = r;
        eval(r);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [2:0] exp_q[$];
        logic [2:0] seen_q[$];
        logic [2:0] r;
        logic [2:0] last_g;
        int owned;
        int pre_cnt;
        int bad_cnt;
        logic pre_at_switch;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        req   = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);

        // Release with all requesting: requester 0 wins one edge later.
        do_reset(3'b111);
        check("first_gnt",   32'(gnt),   32'h1);
        check("first_owner", 32'(owner), 32'd0);

        // Owners release after two cycles each; order 001,010,100,001.
        exp_q  = '{3'b001, 3'b010, 3'b100, 3'b001};
        seen_q = '{};
        seen_q.push_back(gnt);
        last_g = gnt;
        for (int k = 0; k < 20 && seen_q.size() < 4; k++) begin
            r = 3'b111;
            if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
            step(r);
            check("no_gap", 32'(gnt != 3'b000), 32'd1);
            if (gnt != last_g) begin
                seen_q.push_back(gnt);
                last_g = gnt;
            end
        end
        check("order_len", 32'(seen_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen_q.size(); k++) begin
            check("order", 32'(seen_q[k]), 32'(exp_q[k]));
        end

        // req0 held, req1 joins at cycle 3: rotation after 15 owned cycles.
        do_reset(3'b001);
        owned = 1;
        pre_at_switch = 1'b0;
        for (int k = 1; k < 40; k++) begin
            step((k >= 3) ? 3'b011 : 3'b001);
            if (gnt == 3'b001) begin
                owned++;
            end else begin
                pre_at_switch = preempt;
                break;
            end
        end
        check("hold_len",  32'(owned),          32'd15);
        check("rotate_to", 32'(gnt),            32'h2);
        check("pre_pulse", 32'(pre_at_switch),  32'd1);
        step(3'b011);
        check("pre_once",  32'(preempt),        32'd0);

        // req0 alone for 40 cycles: never preempted.
        do_reset(3'b001);
        pre_cnt = 0;
        bad_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(3'b001);
            if (preempt) pre_cnt++;
            if (gnt != 3'b001) bad_cnt++;
        end
        check("solo_pre", 32'(pre_cnt), 32'd0);
        check("solo_gnt", 32'(bad_cnt), 32'd0);

        // Reset between edges while gnt=010 drops the grant immediately.
        do_reset(3'b010);
        step(3'b010);
        check("mid_pre_gnt", 32'(gnt), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_gnt",   32'(gnt),   32'd0);
        check("mid_owner", 32'(owner), 32'd3);
        check("mid_busy",  32'(busy),  32'd0);
        do_reset(3'b010);
        check("mid_regnt", 32'(gnt), 32'h2);

        // Randomised traffic against the model.
        r = 3'b000;
        for (int k = 0; k < 600; k++) begin
            if (k % 150 == 149) begin
                r = 3'($urandom_range(0, 7));
                do_reset(r);
            end else begin
                for (int b = 0; b < 3; b++) begin
                    if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
                end
                step(r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time bound");
        $fatal(1);
    end

endmodule
